// File: rtl/lda_pkg.sv
// ----------------------------------------------------------------------------
// lda_pkg
// Shared definitions for the line-draw accelerator (LDA) controller slice.
//   lda_state_e  : sequencer states
//   LDA_WIDTH    : default canvas width in pixels
//   LDA_HEIGHT   : default canvas height in pixels
//   LDA_MAX_SEGS : default maximum number of segments per batch
//   LDA_TIMEOUT  : default per-segment draw watchdog limit in cycles
//   widthOf()    : $clog2 that never returns zero, for sizing counters
// ----------------------------------------------------------------------------
package lda_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START_DRAW,
        S_DRAW,
        S_DONE
    } lda_state_e;

    localparam int LDA_WIDTH    = 336;
    localparam int LDA_HEIGHT   = 210;
    localparam int LDA_MAX_SEGS = 16;
    localparam int LDA_TIMEOUT  = 4096;

    // A counter that only ever needs to hold one value still needs one bit,
    // so degenerate sizes are pinned to a minimum width of 1.
    function automatic int widthOf(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lda_clear_scanner.sv
// ----------------------------------------------------------------------------
// lda_clear_scanner
// Raster-order x/y sweep used to blank the canvas one pixel per cycle.
//   clk     in   clock
//   reset   in   asynchronous active-high reset
//   en_i    in   advance one pixel this cycle
//   clr_i   in   force the sweep back to (0,0); wins over en_i
//   x_o     out  current column, 0..WIDTH-1
//   y_o     out  current row, 0..HEIGHT-1
//   last_o  out  sweep sits on the final pixel (WIDTH-1,HEIGHT-1)
// ----------------------------------------------------------------------------
module lda_clear_scanner
    import lda_pkg::*;
#(
    parameter int WIDTH  = LDA_WIDTH,
    parameter int HEIGHT = LDA_HEIGHT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en_i,
    input  logic                         clr_i,
    output logic [widthOf(WIDTH)-1:0]    x_o,
    output logic [widthOf(HEIGHT)-1:0]   y_o,
    output logic                         last_o
);

    localparam int X_W = widthOf(WIDTH);
    localparam int Y_W = widthOf(HEIGHT);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           xAtEnd;
    logic           yAtEnd;

    assign xAtEnd = (x_q == X_W'(WIDTH - 1));
    assign yAtEnd = (y_q == Y_W'(HEIGHT - 1));

    // Next sweep position. Column wraps at the right edge and bumps the row;
    // the row wraps after the bottom edge, so a completed sweep lands back on
    // (0,0) and the next clear starts from the origin without extra help.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (xAtEnd) begin
                x_d = '0;
                y_d = yAtEnd ? '0 : (y_q + Y_W'(1));
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    // Sweep position register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = xAtEnd && yAtEnd;

endmodule

// File: rtl/lda_seq_control.sv
// ----------------------------------------------------------------------------
// lda_seq_control
// Batch sequencer for the line-draw accelerator: optional canvas clear, then
// 1..MAX_SEGS segments drawn back to back, with abort and a draw watchdog.
//   clk                in   clock
//   reset              in   asynchronous active-high reset
//   i_start            in   begin a batch (only looked at while idle)
//   i_clear_first      in   with i_start: blank the canvas before drawing
//   i_num_segs         in   with i_start: segment count, clamped to MAX_SEGS
//   i_line_done        in   datapath finished the current segment
//   i_abort            in   drop the running batch
//   o_busy             out  batch in progress
//   o_done             out  one-cycle pulse, batch completed normally
//   o_timeout          out  one-cycle pulse, watchdog dropped the batch
//   o_data_reset       out  datapath holds its registers cleared (idle)
//   o_clear_canvas     out  write black at (o_clear_x, o_clear_y)
//   o_clear_x/y        out  clear sweep position
//   o_start_draw_line  out  one-cycle pulse, load endpoints of o_seg_idx
//   o_draw_line        out  datapath steps the Bresenham engine
//   o_seg_idx          out  current segment index, 0-based
// ----------------------------------------------------------------------------
module lda_seq_control
    import lda_pkg::*;
#(
    parameter int WIDTH    = LDA_WIDTH,
    parameter int HEIGHT   = LDA_HEIGHT,
    parameter int MAX_SEGS = LDA_MAX_SEGS,
    parameter int TIMEOUT  = LDA_TIMEOUT,
    localparam int SEG_W   = $clog2(MAX_SEGS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic                        i_clear_first,
    input  logic [SEG_W-1:0]            i_num_segs,
    input  logic                        i_line_done,
    input  logic                        i_abort,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout,
    output logic                        o_data_reset,
    output logic                        o_clear_canvas,
    output logic [widthOf(WIDTH)-1:0]   o_clear_x,
    output logic [widthOf(HEIGHT)-1:0]  o_clear_y,
    output logic                        o_start_draw_line,
    output logic                        o_draw_line,
    output logic [SEG_W-2:0]            o_seg_idx
);

    localparam int TO_W = widthOf(TIMEOUT + 1);
    localparam logic [TO_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    lda_state_e        state_q, state_d;
    logic [SEG_W-1:0]  numSegs_q, numSegs_d;
    logic [SEG_W-2:0]  segIdx_q, segIdx_d;
    logic [TO_W-1:0]   wdCount_q, wdCount_d;
    logic              timeout_q, timeout_d;

    logic [SEG_W-1:0]  clampedSegs;
    logic              lastSeg;
    logic              wdExpired;
    logic              scanEn;
    logic              scanClr;
    logic              scanLast;

    assign clampedSegs = (i_num_segs > SEG_W'(MAX_SEGS)) ? SEG_W'(MAX_SEGS) : i_num_segs;
    assign lastSeg     = ({1'b0, segIdx_q} == (numSegs_q - SEG_W'(1)));
    assign wdExpired   = (TIMEOUT > 0) && (wdCount_q == WD_LIMIT);

    // The sweep is parked at the origin whenever the controller is idle or a
    // batch is being aborted, so an interrupted clear never leaks its position
    // into the next batch.
    assign scanEn  = (state_q == S_CLEAR);
    assign scanClr = (state_q == S_IDLE) || i_abort;

    lda_clear_scanner #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scanner (
        .clk    (clk),
        .reset  (reset),
        .en_i   (scanEn),
        .clr_i  (scanClr),
        .x_o    (o_clear_x),
        .y_o    (o_clear_y),
        .last_o (scanLast)
    );

    // Next-state logic. Abort outranks everything outside idle. In the draw
    // state a finishing segment is checked before the watchdog, so a segment
    // that completes on the very last allowed cycle still advances normally.
    // The timeout flag is computed here and registered, so the pulse appears
    // in the same cycle the controller is back in idle.
    always_comb begin
        state_d   = state_q;
        numSegs_d = numSegs_q;
        segIdx_d  = segIdx_q;
        wdCount_d = wdCount_q;
        timeout_d = 1'b0;
        if (i_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            numSegs_d = '0;
            segIdx_d  = '0;
            wdCount_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    segIdx_d  = '0;
                    wdCount_d = '0;
                    if (i_start) begin
                        numSegs_d = clampedSegs;
                        if (i_clear_first) begin
                            state_d = S_CLEAR;
                        end else if (clampedSegs != '0) begin
                            state_d = S_START_DRAW;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    if (scanLast) begin
                        state_d = (numSegs_q != '0) ? S_START_DRAW : S_DONE;
                    end
                end
                S_START_DRAW: begin
                    wdCount_d = '0;
                    state_d   = S_DRAW;
                end
                S_DRAW: begin
                    if (i_line_done) begin
                        wdCount_d = '0;
                        if (lastSeg) begin
                            segIdx_d = '0;
                            state_d  = S_DONE;
                        end else begin
                            segIdx_d = segIdx_q + (SEG_W - 1)'(1);
                            state_d  = S_START_DRAW;
                        end
                    end else if (wdExpired) begin
                        state_d   = S_IDLE;
                        segIdx_d  = '0;
                        wdCount_d = '0;
                        timeout_d = 1'b1;
                    end else begin
                        wdCount_d = wdCount_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, batch configuration, segment index and watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            numSegs_q <= '0;
            segIdx_q  <= '0;
            wdCount_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            numSegs_q <= numSegs_d;
            segIdx_q  <= segIdx_d;
            wdCount_q <= wdCount_d;
            timeout_q <= timeout_d;
        end
    end

    // Every strobe is decoded from registered state only, so the datapath
    // never sees a combinational path from the request inputs.
    assign o_busy            = (state_q != S_IDLE);
    assign o_done            = (state_q == S_DONE);
    assign o_timeout         = timeout_q;
    assign o_data_reset      = (state_q == S_IDLE);
    assign o_clear_canvas    = (state_q == S_CLEAR);
    assign o_start_draw_line = (state_q == S_START_DRAW);
    assign o_draw_line       = (state_q == S_DRAW);
    assign o_seg_idx         = segIdx_q;

endmodule

// File: tb/tb_lda_seq_control.sv
// ----------------------------------------------------------------------------
// tb_lda_seq_control
// Scenario bench for lda_seq_control on a 4x3 canvas, 4 segments max and an
// 8-cycle watchdog. A monitor logs every strobe the controller produces as a
// timestamped event; each scenario pushes the events it expects and compares.
// ----------------------------------------------------------------------------
module tb_lda_seq_control;

    localparam int WIDTH    = 4;
    localparam int HEIGHT   = 3;
    localparam int MAX_SEGS = 4;
    localparam int TIMEOUT  = 8;

    typedef enum logic [3:0] {
        EV_NONE,
        EV_START,
        EV_CLEAR,
        EV_DONE,
        EV_TIMEOUT
    } ev_kind_e;

    typedef struct packed {
        ev_kind_e    kind;
        logic [15:0] cyc;
        logic [7:0]  a;
        logic [7:0]  b;
    } ev_t;

    localparam logic [12:0] IDLE_VEC = 13'b0001000_00_00_00;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_clear_first;
    logic [2:0] i_num_segs;
    logic       i_line_done;
    logic       i_abort;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout;
    logic       o_data_reset;
    logic       o_clear_canvas;
    logic [1:0] o_clear_x;
    logic [1:0] o_clear_y;
    logic       o_start_draw_line;
    logic       o_draw_line;
    logic [1:0] o_seg_idx;
    logic [12:0] outVec;

    int  nCmp;
    int  nFail;
    int  cyc;
    int  lineCd;
    ev_t expQ[$];
    ev_t obsQ[$];
    ev_t expEv;
    ev_t obsEv;

    lda_seq_control #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .MAX_SEGS (MAX_SEGS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_start           (i_start),
        .i_clear_first     (i_clear_first),
        .i_num_segs        (i_num_segs),
        .i_line_done       (i_line_done),
        .i_abort           (i_abort),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_timeout         (o_timeout),
        .o_data_reset      (o_data_reset),
        .o_clear_canvas    (o_clear_canvas),
        .o_clear_x         (o_clear_x),
        .o_clear_y         (o_clear_y),
        .o_start_draw_line (o_start_draw_line),
        .o_draw_line       (o_draw_line),
        .o_seg_idx         (o_seg_idx)
    );

    assign outVec = {o_busy, o_done, o_timeout, o_data_reset, o_clear_canvas,
                     o_start_draw_line, o_draw_line, o_clear_x, o_clear_y, o_seg_idx};

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: bumped on every rising edge, so a value read just after an
    // edge names the cycle the outputs now belong to.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkEv(input ev_kind_e k, input int c, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.cyc  = 16'(c);
        e.a    = 8'(a);
        e.b    = 8'(b);
        return e;
    endfunction

    function automatic void pushExp(input ev_kind_e k, input int c, input int a, input int b);
        expQ.push_back(mkEv(k, c, a, b));
    endfunction

    // Monitor: on the falling edge, log each strobe the controller shows.
    // Done and timeout events carry o_busy so its value at the pulse is checked.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_start_draw_line) obsQ.push_back(mkEv(EV_START, cyc, int'(o_seg_idx), 0));
            if (o_clear_canvas)    obsQ.push_back(mkEv(EV_CLEAR, cyc, int'(o_clear_x), int'(o_clear_y)));
            if (o_done)            obsQ.push_back(mkEv(EV_DONE, cyc, int'(o_busy), 0));
            if (o_timeout)         obsQ.push_back(mkEv(EV_TIMEOUT, cyc, int'(o_busy), 0));
        end
    end

    // Run a number of cycles while playing the datapath: lineDelay cycles
    // after each start_draw pulse, raise i_line_done for one cycle (0 = never).
    task automatic applyStimulus(input int cycles, input int lineDelay);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (o_start_draw_line && lineDelay > 0) lineCd = lineDelay;
            @(posedge clk);
            #1;
            i_line_done = 1'b0;
            if (lineCd > 0) begin
                lineCd = lineCd - 1;
                if (lineCd == 0) i_line_done = 1'b1;
            end
        end
    endtask

    // Present a start request for one cycle; s returns the request cycle.
    task automatic startBatch(input logic clr, input logic [2:0] n, input int lineDelay, output int s);
        s             = cyc;
        i_start       = 1'b1;
        i_clear_first = clr;
        i_num_segs    = n;
        applyStimulus(1, lineDelay);
        i_start       = 1'b0;
        i_clear_first = 1'b0;
        i_num_segs    = '0;
    endtask

    task automatic beginScenario();
        expQ.delete();
        obsQ.delete();
        lineCd      = 0;
        i_line_done = 1'b0;
    endtask

    // Reset values while reset is held, after release, and idle ignoring
    // abort/line_done.
    task automatic test_reset();
        reset = 1'b1;
        #2;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL reset_asserted: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        @(posedge clk);
        #1;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL reset_held: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL reset_released: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        i_abort     = 1'b1;
        i_line_done = 1'b1;
        @(posedge clk);
        #1;
        i_abort     = 1'b0;
        i_line_done = 1'b0;
        @(posedge clk);
        #1;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL idle_ignore: outputs %b, expected %b", outVec, IDLE_VEC);
        end
    endtask

    // Three segments, no clear; each line takes 5 cycles after its start
    // pulse, so start pulses are 6 cycles apart and done follows the last.
    task automatic test_polyline();
        int s;
        beginScenario();
        startBatch(1'b0, 3'd3, 5, s);
        for (int k = 0; k < 3; k++) pushExp(EV_START, s + 1 + 6 * k, k, 0);
        pushExp(EV_DONE, s + 19, 1, 0);
        applyStimulus(19, 5);
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL polyline_idle: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL polyline_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL polyline_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Clear first, then one segment: 12 raster-order pixels, then the draw.
    task automatic test_clear_then_draw();
        int s;
        beginScenario();
        startBatch(1'b1, 3'd1, 3, s);
        for (int i = 0; i < WIDTH * HEIGHT; i++) pushExp(EV_CLEAR, s + 1 + i, i % WIDTH, i / WIDTH);
        pushExp(EV_START, s + 13, 0, 0);
        pushExp(EV_DONE, s + 17, 1, 0);
        applyStimulus(18, 3);
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL clear_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL clear_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Zero segments: straight to done, and after a full clear to done.
    task automatic test_zero_segs();
        int s;
        int s2;
        beginScenario();
        startBatch(1'b0, 3'd0, 0, s);
        pushExp(EV_DONE, s + 1, 1, 0);
        applyStimulus(4, 0);
        startBatch(1'b1, 3'd0, 0, s2);
        for (int i = 0; i < WIDTH * HEIGHT; i++) pushExp(EV_CLEAR, s2 + 1 + i, i % WIDTH, i / WIDTH);
        pushExp(EV_DONE, s2 + 13, 1, 0);
        applyStimulus(14, 0);
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL zero_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL zero_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Seven requested segments clamp to four; a second start mid-batch is ignored.
    task automatic test_clamp_busy_start();
        int s;
        beginScenario();
        startBatch(1'b0, 3'd7, 2, s);
        for (int k = 0; k < MAX_SEGS; k++) pushExp(EV_START, s + 1 + 3 * k, k, 0);
        pushExp(EV_DONE, s + 13, 1, 0);
        applyStimulus(3, 2);
        i_start       = 1'b1;
        i_clear_first = 1'b1;
        i_num_segs    = 3'd1;
        applyStimulus(1, 2);
        i_start       = 1'b0;
        i_clear_first = 1'b0;
        i_num_segs    = '0;
        applyStimulus(10, 2);
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL clamp_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL clamp_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Silent datapath: timeout after 8 draw cycles, idle and no done.
    // Then line_done exactly on the 8th draw cycle: normal advance instead.
    task automatic test_watchdog();
        int s;
        int s2;
        beginScenario();
        startBatch(1'b0, 3'd1, 0, s);
        pushExp(EV_START, s + 1, 0, 0);
        pushExp(EV_TIMEOUT, s + 10, 0, 0);
        applyStimulus(13, 0);
        startBatch(1'b0, 3'd2, 8, s2);
        pushExp(EV_START, s2 + 1, 0, 0);
        pushExp(EV_START, s2 + 10, 1, 0);
        pushExp(EV_DONE, s2 + 19, 1, 0);
        applyStimulus(20, 8);
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL watchdog_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL watchdog_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Abort mid-clear at (2,1) and mid-draw of segment 2, then a fresh batch
    // that must start again at segment 0.
    task automatic test_abort();
        int s;
        int s2;
        int s3;
        beginScenario();
        startBatch(1'b1, 3'd2, 3, s);
        for (int i = 0; i <= 6; i++) pushExp(EV_CLEAR, s + 1 + i, i % WIDTH, i / WIDTH);
        applyStimulus(6, 3);
        nCmp++;
        if ({o_clear_canvas, o_clear_x, o_clear_y} !== 5'b1_10_01) begin
            nFail++;
            $display("[TB] FAIL abort_clear_pos: got %b, expected %b", {o_clear_canvas, o_clear_x, o_clear_y}, 5'b1_10_01);
        end
        i_abort = 1'b1;
        applyStimulus(1, 3);
        i_abort = 1'b0;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL abort_clear_idle: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        applyStimulus(5, 3);
        startBatch(1'b0, 3'd4, 3, s2);
        for (int k = 0; k < 3; k++) pushExp(EV_START, s2 + 1 + 4 * k, k, 0);
        applyStimulus(10, 3);
        nCmp++;
        if ({o_draw_line, o_seg_idx} !== 3'b1_10) begin
            nFail++;
            $display("[TB] FAIL abort_draw_seg: got %b, expected %b", {o_draw_line, o_seg_idx}, 3'b1_10);
        end
        i_abort = 1'b1;
        applyStimulus(1, 3);
        i_abort = 1'b0;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL abort_draw_idle: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        applyStimulus(6, 3);
        startBatch(1'b0, 3'd1, 1, s3);
        pushExp(EV_START, s3 + 1, 0, 0);
        pushExp(EV_DONE, s3 + 3, 1, 0);
        applyStimulus(4, 1);
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL abort_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL abort_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Reset pulsed between clock edges while drawing: outputs must return to
    // reset values before any edge, and the batch must never report done.
    task automatic test_async_reset();
        int s;
        beginScenario();
        startBatch(1'b0, 3'd2, 4, s);
        pushExp(EV_START, s + 1, 0, 0);
        applyStimulus(2, 4);
        nCmp++;
        if (o_draw_line !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL areset_pre_draw: got %b, expected %b", o_draw_line, 1'b1);
        end
        #1 reset = 1'b1;
        #1;
        nCmp++;
        if (outVec !== IDLE_VEC) begin
            nFail++;
            $display("[TB] FAIL areset_outputs: outputs %b, expected %b", outVec, IDLE_VEC);
        end
        #1 reset = 1'b0;
        lineCd      = 0;
        i_line_done = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(6, 4);
        nCmp++;
        if (obsQ.size() != expQ.size()) begin
            nFail++;
            $display("[TB] FAIL areset_count: got %0d events, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expEv = expQ.pop_front();
            obsEv = obsQ.pop_front();
            nCmp++;
            if (obsEv !== expEv) begin
                nFail++;
                $display("[TB] FAIL areset_event: got k%0d c%0d a%0d b%0d, expected k%0d c%0d a%0d b%0d",
                         obsEv.kind, obsEv.cyc, obsEv.a, obsEv.b, expEv.kind, expEv.cyc, expEv.a, expEv.b);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        nCmp          = 0;
        nFail         = 0;
        lineCd        = 0;
        reset         = 1'b1;
        i_start       = 1'b0;
        i_clear_first = 1'b0;
        i_num_segs    = '0;
        i_line_done   = 1'b0;
        i_abort       = 1'b0;
        $display("[TB] lda_seq_control scenarios starting");
        test_reset();
        test_polyline();
        test_clear_then_draw();
        test_zero_segs();
        test_clamp_busy_start();
        test_watchdog();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
